// File: rtl/sme_feeder_pkg.sv
// sme_feeder_pkg: shared types and constants for the SME feeder
package sme_feeder_pkg;
  typedef enum logic [2:0] {RX_HDR, RX_BODY, DROP, EMIT, WAIT} state_t;
  localparam logic [1:0] ERR_LEN = 2'd1;
  localparam logic [1:0] ERR_TMO = 2'd2;
  localparam int HDR_TYPE_BIT = 7;
  localparam int HDR_LEN_MSB = 5;
  localparam logic TYPE_STR = 1'b0;
  localparam logic TYPE_PAT = 1'b1;
endpackage

// File: rtl/sme_rec_buf.sv
// sme_rec_buf: record byte store, synchronous write, combinational read
module sme_rec_buf #(
  parameter int DEPTH = 32,
  parameter int AW = 6
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);
  localparam int IW = $clog2(DEPTH);
  logic [7:0] mem [DEPTH];
  // payload bytes land at the receive counter position
  always_ff @(posedge clk)
    if (we) mem[waddr[IW-1:0]] <= wdata;
  assign rdata = mem[raddr[IW-1:0]];
endmodule

// File: rtl/sme_feeder.sv
// sme_feeder: buffers framed records and replays them to SME as contiguous bursts
module sme_feeder
  import sme_feeder_pkg::*;
#(
  parameter int STR_MAX = 32,
  parameter int PAT_MAX = 8,
  parameter int WAIT_MAX = 1023
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] chardata,
  output logic       isstring,
  output logic       ispattern,
  input  logic       sme_valid,
  input  logic       sme_match,
  input  logic [4:0] sme_match_index,
  output logic       res_valid,
  output logic       res_match,
  output logic [4:0] res_index,
  output logic       err,
  output logic [1:0] err_code,
  output logic       busy
);
  localparam int LW = $clog2(STR_MAX + 1);
  localparam int CW = LW > HDR_LEN_MSB + 1 ? LW : HDR_LEN_MSB + 1;
  localparam int WW = $clog2(WAIT_MAX + 1);
  state_t state;
  logic typ;
  logic [CW-1:0] len, cnt, hdr_len;
  logic [WW-1:0] wcnt;
  logic [7:0] rd_data;
  logic xfer, hdr_ok;
  assign xfer = in_valid && in_ready;
  assign hdr_len = CW'(in_data[HDR_LEN_MSB:0]);
  assign hdr_ok = hdr_len != '0 && hdr_len <= CW'(in_data[HDR_TYPE_BIT] ? PAT_MAX : STR_MAX);
  sme_rec_buf #(.DEPTH(STR_MAX), .AW(CW)) u_buf (
    .clk  (clk),
    .we   (state == RX_BODY && xfer),
    .waddr(cnt),
    .wdata(in_data),
    .raddr(state == EMIT ? cnt : '0),
    .rdata(rd_data)
  );
  // record framing, burst replay and result/timeout handling
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= RX_HDR;
      typ <= TYPE_STR;
      len <= '0;
      cnt <= '0;
      wcnt <= '0;
      in_ready <= 1'b0;
      chardata <= '0;
      isstring <= 1'b0;
      ispattern <= 1'b0;
      res_valid <= 1'b0;
      res_match <= 1'b0;
      res_index <= '0;
      err <= 1'b0;
      err_code <= '0;
      busy <= 1'b0;
    end else begin
      res_valid <= 1'b0;
      err <= 1'b0;
      case (state)
        RX_HDR: begin
          in_ready <= 1'b1;
          if (xfer) begin
            typ <= in_data[HDR_TYPE_BIT];
            len <= hdr_len;
            cnt <= '0;
            if (hdr_ok) begin
              state <= RX_BODY;
              busy <= 1'b1;
            end else begin
              err <= 1'b1;
              err_code <= ERR_LEN;
              if (hdr_len != '0) begin
                state <= DROP;
                busy <= 1'b1;
              end
            end
          end
        end
        RX_BODY: if (xfer) begin
          if (cnt == len - CW'(1)) begin
            state <= EMIT;
            in_ready <= 1'b0;
            isstring <= typ == TYPE_STR;
            ispattern <= typ == TYPE_PAT;
            chardata <= cnt == '0 ? in_data : rd_data;
            cnt <= CW'(1);
          end else cnt <= cnt + CW'(1);
        end
        DROP: if (xfer) begin
          if (cnt == len - CW'(1)) begin
            state <= RX_HDR;
            busy <= 1'b0;
          end else cnt <= cnt + CW'(1);
        end
        EMIT: begin
          if (cnt == len) begin
            isstring <= 1'b0;
            ispattern <= 1'b0;
            chardata <= '0;
            cnt <= '0;
            wcnt <= '0;
            if (typ == TYPE_PAT) state <= WAIT;
            else begin
              state <= RX_HDR;
              in_ready <= 1'b1;
              busy <= 1'b0;
            end
          end else begin
            chardata <= rd_data;
            cnt <= cnt + CW'(1);
          end
        end
        WAIT: begin
          if (sme_valid) begin
            res_valid <= 1'b1;
            res_match <= sme_match;
            res_index <= sme_match_index;
            state <= RX_HDR;
            in_ready <= 1'b1;
            busy <= 1'b0;
          end else if (wcnt == WW'(WAIT_MAX - 1)) begin
            err <= 1'b1;
            err_code <= ERR_TMO;
            state <= RX_HDR;
            in_ready <= 1'b1;
            busy <= 1'b0;
          end else wcnt <= wcnt + WW'(1);
        end
        default: state <= RX_HDR;
      endcase
    end
endmodule

// File: tb/tb_sme_feeder.sv
// tb_sme_feeder: directed self-checking bench for sme_feeder
module tb_sme_feeder;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [7:0] in_data = '0;
  logic in_valid = 1'b0;
  logic sme_valid = 1'b0;
  logic sme_match = 1'b0;
  logic [4:0] sme_match_index = '0;
  logic in_ready, isstring, ispattern, res_valid, res_match, err, busy;
  logic [7:0] chardata;
  logic [4:0] res_index;
  logic [1:0] err_code;
  logic [7:0] exp_b [32];
  int checks = 0;
  int errors = 0;

  sme_feeder #(.STR_MAX(32), .PAT_MAX(8), .WAIT_MAX(15)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .chardata(chardata), .isstring(isstring), .ispattern(ispattern),
    .sme_valid(sme_valid), .sme_match(sme_match), .sme_match_index(sme_match_index),
    .res_valid(res_valid), .res_match(res_match), .res_index(res_index),
    .err(err), .err_code(err_code), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b, input bit gaps);
    int t;
    if (gaps) begin
      in_valid = 1'b0;
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    in_valid = 1'b1;
    in_data = b;
    t = 0;
    while (!in_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) begin
      checks++;
      errors++;
      $error("FAIL send_wait: in_ready observed 0 expected 1");
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send_rec(input logic [7:0] hdr, input int n, input bit gaps);
    send(hdr, gaps);
    for (int i = 0; i < n; i++) send(exp_b[i], gaps);
  endtask

  task automatic burst(input bit pat, input int n);
    for (int i = 0; i < n; i++) begin
      check($sformatf("burst_%0d", i), {isstring, ispattern, chardata, in_ready, res_valid, err},
            {!pat, pat, exp_b[i], 3'b000});
      @(negedge clk);
    end
    check("burst_end", {isstring, ispattern, chardata}, 10'd0);
    check("burst_ready", {in_ready, busy}, pat ? 2'b01 : 2'b10);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("reset_outs", {in_ready, isstring, ispattern, res_valid, res_match, err, busy, chardata, res_index, err_code}, 0);
    reset = 1'b0;
    @(negedge clk);
    check("ready_after_reset", {in_ready, busy}, 2'b10);

    exp_b[0] = 8'h61; exp_b[1] = 8'h62; exp_b[2] = 8'h63; exp_b[3] = 8'h64;
    send_rec(8'h04, 4, 1'b0);
    burst(1'b0, 4);

    exp_b[0] = 8'h62; exp_b[1] = 8'h63;
    send_rec(8'h82, 2, 1'b0);
    burst(1'b1, 2);
    repeat (2) begin
      @(negedge clk);
      check("pat_wait", {in_ready, res_valid, busy}, 3'b001);
    end
    sme_valid = 1'b1; sme_match = 1'b1; sme_match_index = 5'd1;
    @(negedge clk);
    sme_valid = 1'b0; sme_match = 1'b0; sme_match_index = 5'd0;
    check("pat_result", {res_valid, res_match, res_index, in_ready, busy}, {1'b1, 1'b1, 5'd1, 1'b1, 1'b0});
    @(negedge clk);
    check("pat_result_hold", {res_valid, res_match, res_index}, {1'b0, 1'b1, 5'd1});
    sme_valid = 1'b1; sme_match = 1'b0; sme_match_index = 5'd7;
    @(negedge clk);
    sme_valid = 1'b0;
    @(negedge clk);
    check("sme_valid_ignored", {res_valid, res_match, res_index}, {1'b0, 1'b1, 5'd1});

    send(8'h89, 1'b0);
    check("len_err_pat9", {err, err_code, busy, in_ready}, {1'b1, 2'd1, 1'b1, 1'b1});
    for (int i = 0; i < 9; i++) begin
      send(8'hA0 + 8'(i), 1'b0);
      check("drop_no_strobe", {isstring, ispattern, err}, 3'b000);
    end
    check("drop_done", {err, err_code, busy, in_ready}, {1'b0, 2'd1, 1'b0, 1'b1});
    exp_b[0] = 8'h5A;
    send_rec(8'h01, 1, 1'b0);
    burst(1'b0, 1);

    send(8'h00, 1'b0);
    check("len_err_zero", {err, err_code, busy, in_ready}, {1'b1, 2'd1, 1'b0, 1'b1});
    @(negedge clk);
    check("err_one_cycle", {err, err_code}, {1'b0, 2'd1});

    exp_b[0] = 8'h78; exp_b[1] = 8'h79;
    send_rec(8'h42, 2, 1'b0);
    burst(1'b0, 2);

    send(8'h21, 1'b0);
    check("len_err_str33", {err, err_code, busy}, {1'b1, 2'd1, 1'b1});
    for (int i = 0; i < 33; i++) send(8'(i), 1'b0);
    check("drop33_done", {busy, in_ready, isstring}, 3'b010);

    exp_b[0] = 8'h71;
    send_rec(8'h81, 1, 1'b0);
    burst(1'b1, 1);
    for (int j = 1; j < 15; j++) begin
      @(negedge clk);
      check($sformatf("tmo_wait_%0d", j), {err, in_ready, busy}, 3'b001);
    end
    @(negedge clk);
    check("timeout", {err, err_code, in_ready, res_valid, busy}, {1'b1, 2'd2, 1'b1, 1'b0, 1'b0});

    for (int i = 0; i < 32; i++) exp_b[i] = 8'(i * 7 + 3);
    send_rec(8'h20, 32, 1'b1);
    burst(1'b0, 32);

    for (int i = 0; i < 8; i++) exp_b[i] = 8'h30 + 8'(i);
    send_rec(8'h08, 8, 1'b0);
    check("pre_reset_c1", {isstring, chardata}, {1'b1, 8'h30});
    repeat (2) @(negedge clk);
    check("pre_reset_c3", {isstring, chardata}, {1'b1, 8'h32});
    reset = 1'b1;
    #1;
    check("mid_emit_reset", {in_ready, isstring, ispattern, res_valid, res_match, err, busy, chardata, res_index, err_code}, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("ready_after_reset2", {in_ready, busy}, 2'b10);
    exp_b[0] = 8'h68; exp_b[1] = 8'h69;
    send_rec(8'h02, 2, 1'b0);
    burst(1'b0, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
